// File: rtl/mem_display_pkg.sv
// Shared types and constants for mem_display_ctrl: FSM state encoding,
// default window placement and the digit layout of disp_word.
package mem_display_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2
  } state_t;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0004;
  localparam int          DEF_STRIDE    = 4;

  // disp_word is four hex digits, digit 3 = [15:12] drives the leftmost place
  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int DISP_W     = DIGIT_W * NUM_DIGITS;

  function automatic logic [DIGIT_W-1:0] disp_digit(input logic [DISP_W-1:0] word,
                                                    input int pos);
    return word[pos*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/mem_display_ctrl_btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted press. Usable for any board button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic level,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             accept;

  assign differ = (sync_2 != level);
  assign accept = differ && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
      // any return to the accepted level restarts the stability window
      if (!differ || accept) cnt <= '0;
      else                   cnt <= cnt + CNT_W'(1);
      if (accept) level <= sync_2;
      pulse <= accept && sync_2;
    end
  end

endmodule

// File: rtl/mem_display_ctrl.sv
// Hands the DataMemory port from the CPU to the 7-segment result viewer once
// the CPU is done. Optional timed auto-advance under DISP_AUTO_STEP_EN.
//
//   state | meaning
//   RUN   | CPU owns the memory port, bus passes straight through
//   LOAD  | read word at ptr, capture it into disp_word on the next edge
//   SHOW  | hold the displayed word until the next advance
module mem_display_ctrl
  import mem_display_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = DEF_BASE_ADDR,
  parameter int          STRIDE          = DEF_STRIDE,
  parameter int          NUM_WORDS       = 16,
  parameter int          DEBOUNCE_CYCLES = 20000,
  parameter int          AUTO_PERIOD     = 10000000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cpu_done,
  input  logic                         cpu_mem_read,
  input  logic                         cpu_mem_write,
  input  logic [31:0]                  cpu_mem_addr,
  input  logic                         next_btn,
  input  logic [31:0]                  mem_rdata,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [31:0]                  mem_addr,
  output logic [DISP_W-1:0]            disp_word,
  output logic                         disp_valid,
  output logic [$clog2(NUM_WORDS)-1:0] disp_index
);

  localparam int PTR_W = $clog2(NUM_WORDS);

  state_t           state;
  state_t           state_nxt;
  logic [PTR_W-1:0] ptr;
  logic             done_latched;
  logic             btn_pulse;
  logic             advance;
  logic [31:0]      word_addr;
  logic             unused_btn_level;
  logic             unused_rdata_hi;

  assign unused_rdata_hi = ^mem_rdata[31:DISP_W];

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_next_btn (
    .clk    (clk),
    .reset_n(reset_n),
    .btn    (next_btn),
    .level  (unused_btn_level),
    .pulse  (btn_pulse)
  );

`ifdef DISP_AUTO_STEP_EN
  localparam int AUTO_W = $clog2(AUTO_PERIOD + 1);

  logic [AUTO_W-1:0] auto_cnt;
  logic              auto_tick;

  assign auto_tick = (state == SHOW) && (auto_cnt == AUTO_W'(AUTO_PERIOD - 1));
  assign advance   = btn_pulse || auto_tick;

  // counts SHOW cycles only; any advance (button or timer) restarts it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          auto_cnt <= '0;
    else if ((state == SHOW) && !advance)  auto_cnt <= auto_cnt + AUTO_W'(1);
    else                                   auto_cnt <= '0;
  end
`else
  localparam int unused_auto_period = AUTO_PERIOD;

  assign advance = btn_pulse;
`endif

  assign word_addr = BASE_ADDR + 32'(ptr) * 32'(STRIDE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (cpu_done || done_latched) state_nxt = LOAD;
      LOAD:    state_nxt = SHOW;
      SHOW:    if (advance) state_nxt = LOAD;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    mem_read  = 1'b1;
    mem_write = 1'b0;
    mem_addr  = word_addr;
    if (state == RUN) begin
      mem_read  = cpu_mem_read;
      mem_write = cpu_mem_write;
      mem_addr  = cpu_mem_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr          <= '0;
      done_latched <= 1'b0;
      disp_word    <= '0;
      disp_valid   <= 1'b0;
      disp_index   <= '0;
    end else begin
      case (state)
        RUN: if (cpu_done) begin
          done_latched <= 1'b1;
          ptr          <= '0;
        end
        LOAD: begin
          disp_word  <= mem_rdata[DISP_W-1:0];
          disp_index <= ptr;
          disp_valid <= 1'b1;
        end
        SHOW: if (advance) begin
          ptr <= (ptr == PTR_W'(NUM_WORDS - 1)) ? '0 : ptr + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_display_ctrl.sv
// Directed + randomized bench for mem_display_ctrl with a small window
// (4 words, 4-cycle debounce, 8-cycle auto period when DISP_AUTO_STEP_EN).
module tb_mem_display_ctrl;

  localparam int NW  = 4;
  localparam int DEB = 4;
  localparam int AP  = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_done;
  logic        cpu_mem_read;
  logic        cpu_mem_write;
  logic [31:0] cpu_mem_addr;
  logic        next_btn;
  logic [31:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [15:0] disp_word;
  logic        disp_valid;
  logic [1:0]  disp_index;

  logic [31:0] mem [0:63];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  mem_display_ctrl #(
    .BASE_ADDR      (32'h0000_0004),
    .STRIDE         (4),
    .NUM_WORDS      (NW),
    .DEBOUNCE_CYCLES(DEB),
    .AUTO_PERIOD    (AP)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_done     (cpu_done),
    .cpu_mem_read (cpu_mem_read),
    .cpu_mem_write(cpu_mem_write),
    .cpu_mem_addr (cpu_mem_addr),
    .next_btn     (next_btn),
    .mem_rdata    (mem_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .disp_word    (disp_word),
    .disp_valid   (disp_valid),
    .disp_index   (disp_index)
  );

  // reference: window entry i lives at BASE + i*STRIDE
  function automatic logic [31:0] exp_addr(input int i);
    return 32'h4 + 32'(i) * 32'd4;
  endfunction

  function automatic logic [15:0] exp_word(input int i);
    logic [31:0] a;
    a = exp_addr(i);
    return mem[a[7:2]][15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int hold);
    next_btn = 1'b1;
    step(hold);
    next_btn = 1'b0;
    step(12);
  endtask

  int          cur;
  int          n;
  logic [1:0]  old_idx;
  logic        r, w;
  logic [31:0] a;

  initial begin
    reset_n       = 1'b0;
    cpu_done      = 1'b0;
    cpu_mem_read  = 1'b0;
    cpu_mem_write = 1'b0;
    cpu_mem_addr  = 32'h0;
    next_btn      = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[1] = 32'h0000_ABCD;
    #12;
    chk("rst_disp_valid", {31'b0, disp_valid}, 32'd0);
    chk("rst_disp_word",  {16'b0, disp_word},  32'd0);
    chk("rst_disp_index", {30'b0, disp_index}, 32'd0);
    reset_n = 1'b1;
    step(2);

    cpu_mem_write = 1'b1; cpu_mem_read = 1'b0; cpu_mem_addr = 32'h10;
    #1;
    chk("pt_write", {31'b0, mem_write}, 32'd1);
    chk("pt_addr",  mem_addr,           32'h10);
    chk("pt_read",  {31'b0, mem_read},  32'd0);
    chk("pt_valid", {31'b0, disp_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      r = 1'($urandom); w = 1'($urandom); a = $urandom;
      cpu_mem_read = r; cpu_mem_write = w; cpu_mem_addr = a;
      step(1);
      chk("pt_rnd_addr", mem_addr, a);
      chk("pt_rnd_rw",   {30'b0, mem_read, mem_write}, {30'b0, r, w});
    end

`ifndef DISP_AUTO_STEP_EN
    // a press while the CPU still runs must not be remembered
    press(8);
`endif

    cpu_done = 1'b1; cpu_mem_write = 1'b1; cpu_mem_read = 1'b0; cpu_mem_addr = 32'h20;
    #1;
    chk("ho_last_cpu_write", {31'b0, mem_write}, 32'd1);
    step(1);
    chk("ho_load_addr",  mem_addr,           32'h4);
    chk("ho_load_read",  {31'b0, mem_read},  32'd1);
    chk("ho_load_wrblk", {31'b0, mem_write}, 32'd0);
    step(1);
    chk("ho_word",  {16'b0, disp_word},   32'h0000_ABCD);
    chk("ho_valid", {31'b0, disp_valid},  32'd1);
    chk("ho_index", {30'b0, disp_index},  32'd0);
    chk("ho_wrblk", {31'b0, mem_write},   32'd0);
    cur = 0;

`ifndef DISP_AUTO_STEP_EN
    step(30);
    chk("idle_no_advance", {30'b0, disp_index}, 32'd0);

    for (int k = 0; k < 5; k++) begin
      press(int'($urandom_range(4, 10)));
      cur = (cur + 1) % NW;
      chk("step_index", {30'b0, disp_index}, 32'(cur));
      chk("step_addr",  mem_addr,            exp_addr(cur));
      chk("step_word",  {16'b0, disp_word},  {16'b0, exp_word(cur)});
    end

    press(3);
    chk("glitch_no_adv", {30'b0, disp_index}, 32'(cur));
    press(100);
    cur = (cur + 1) % NW;
    chk("long_press_once", {30'b0, disp_index}, 32'(cur));

    cpu_done = 1'b0; cpu_mem_write = 1'b1; cpu_mem_read = 1'b0;
    step(5);
    chk("sticky_wrblk", {31'b0, mem_write}, 32'd0);
    chk("sticky_read",  {31'b0, mem_read},  32'd1);
    chk("sticky_addr",  mem_addr,           exp_addr(cur));

    old_idx = disp_index;
    next_btn = 1'b1;
    n = 0;
    while (mem_addr == exp_addr(cur) && n < 40) begin
      step(1);
      n++;
    end
    chk("load_seen_in_time", {31'b0, n < 40}, 32'd1);
    cur = (cur + 1) % NW;
    chk("load_addr_next", mem_addr,            exp_addr(cur));
    chk("load_index_held", {30'b0, disp_index}, {30'b0, old_idx});
    reset_n = 1'b0; next_btn = 1'b0; cpu_mem_addr = 32'h44;
    #1;
    chk("mid_rst_valid", {31'b0, disp_valid}, 32'd0);
    chk("mid_rst_index", {30'b0, disp_index}, 32'd0);
    chk("mid_rst_addr",  mem_addr,            32'h44);
    chk("mid_rst_write", {31'b0, mem_write},  32'd1);
    step(1);
    reset_n = 1'b1;
    step(3);
    chk("post_rst_run_addr", mem_addr, 32'h44);
    chk("post_rst_valid",    {31'b0, disp_valid}, 32'd0);
`else
    // timed advance: 8 SHOW cycles + 1 LOAD cycle between captures
    for (int k = 0; k < 5; k++) begin
      old_idx = disp_index;
      n = 0;
      while (disp_index == old_idx && n < 40) begin
        step(1);
        n++;
      end
      cur = (cur + 1) % NW;
      chk("auto_period", 32'(n), 32'(AP + 1));
      chk("auto_index",  {30'b0, disp_index}, 32'(cur));
      chk("auto_word",   {16'b0, disp_word},  {16'b0, exp_word(cur)});
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_display_ctrl.md
Name: mem_display_ctrl

Overview:
- Sequences the single DataMemory port between the CPU and the 7-segment readout.
- While the CPU runs, all CPU bus signals pass through unchanged.
- Once the CPU signals completion, the block takes the memory port. It then walks a window of result words, one per debounced "next" button press, and latches each word's low 16 bits for scan_output.
- Sits between CPU, DataMemory and scan_output in the board top level, all on the CPU clock domain.

Parameters:
- BASE_ADDR, 32'h00000004, byte address of first displayed word
- STRIDE, 4, byte increment between displayed words
- NUM_WORDS, 16, number of words in the display window (>=2); index wraps after NUM_WORDS-1
- DEBOUNCE_CYCLES, 20000, consecutive stable clk cycles required to accept a button level change
- AUTO_PERIOD, 10000000, clk cycles per auto-advance (used only with the optional feature)

Ports:
- clk  in  1  system clock, single domain
- reset_n  in  1  asynchronous active-low reset
- cpu_done  in  1  CPU finished execution; level; sampled synchronously
- cpu_mem_read  in  1  CPU read strobe
- cpu_mem_write  in  1  CPU write strobe
- cpu_mem_addr  in  32  CPU byte address
- next_btn  in  1  raw asynchronous push-button, active-high
- mem_rdata  in  32  DataMemory read data; combinational read of mem_addr
- mem_read  out  1  DataMemory read enable
- mem_write  out  1  DataMemory write enable
- mem_addr  out  32  DataMemory address
- disp_word  out  16  digits for scan_output: [15:12] leftmost … [3:0] rightmost
- disp_valid  out  1  disp_word holds a captured memory value
- disp_index  out  $clog2(NUM_WORDS)  window index of disp_word

Behaviour:
- Reset (reset_n low, async) values:
  - state=RUN, ptr=0, done_latched=0
  - disp_word=0, disp_valid=0, disp_index=0
  - debounce sync/counter/level=0
  - All take effect immediately; reset mid-walk returns to RUN and hands the port back to the CPU.
- States: RUN, LOAD, SHOW.
- RUN:
  - mem_read=cpu_mem_read, mem_write=cpu_mem_write, mem_addr=cpu_mem_addr (combinational pass-through).
  - On a clk edge with cpu_done=1: done_latched<=1, ptr<=0, next state LOAD.
  - A CPU access in the cycle cpu_done first rises still completes, because the state change is registered.
- LOAD:
  - mem_read=1, mem_write=0, mem_addr=BASE_ADDR+ptr*STRIDE (32-bit, modulo 2^32).
  - Next edge: disp_word<=mem_rdata[15:0], disp_index<=ptr, disp_valid<=1, next state SHOW.
  - Fixed latency: exactly one cycle in LOAD.
- SHOW:
  - mem_read=1, mem_write=0, mem_addr held at the current word.
  - On next_pulse: ptr<=(ptr==NUM_WORDS-1)?0:ptr+1, next state LOAD.
  - disp_word/disp_index keep their old values until the LOAD capture.
- done_latched is sticky. cpu_done dropping after LOAD/SHOW is entered is ignored; only reset returns to RUN.
- CPU writes are blocked in LOAD/SHOW (mem_write=0) regardless of cpu_mem_write.
- next_pulse arriving in RUN or LOAD is dropped, not queued.
- disp_valid stays 1 through subsequent LOADs once set.
- Button path:
  - Two-flop synchroniser feeds a debounce counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive cycles differing from the current accepted level; the counter clears on any bounce.
  - next_pulse = one-cycle pulse on an accepted 0->1 change. Holding the button gives exactly one pulse.

Optional Feature:
- Macro: DISP_AUTO_STEP_EN.
- Defined:
  - A cycle counter runs only in SHOW and clears on entering LOAD.
  - Reaching AUTO_PERIOD-1 generates an internal advance identical to next_pulse.
  - The button still works; a simultaneous button press and auto-advance produce a single advance.
- Undefined: no counter logic is synthesised; advance only via the button.

Decomposition:
- Package mem_display_pkg:
  - state enum (RUN, LOAD, SHOW)
  - the BASE_ADDR/STRIDE defaults as localparams
  - the digit-field slicing constants for disp_word
- Sub-module btn_debounce (synchroniser + DEBOUNCE_CYCLES counter + rising-edge pulse). It is reusable for other board buttons.

Test Plan:
- Pass-through: cpu_done=0; drive cpu_mem_write=1, addr=0x10, cpu_mem_read=0 -> mem_write=1, mem_addr=0x10, mem_read=0, disp_valid=0.
- Handover:
  - Memory preloaded with word[1]=0x0000ABCD; assert cpu_done.
  - Required: after 1 edge mem_addr=0x4, mem_read=1; after 2 edges disp_word=0xABCD, disp_valid=1, disp_index=0.
  - cpu_mem_write=1 afterwards -> mem_write=0.
- Step and wrap (DEBOUNCE_CYCLES=4, NUM_WORDS=4):
  - Each press (held >=4 stable cycles) sequences mem_addr 0x8, 0xC, 0x10, 0x4 and disp_index 1, 2, 3, 0.
  - A 3-cycle glitch produces no advance.
  - A press held 100 cycles advances exactly once.
- Sticky done: drop cpu_done while in SHOW -> state stays SHOW and CPU writes remain blocked. Assert reset_n=0 mid-LOAD -> immediate RUN, disp_valid=0, pass-through restored.
- DISP_AUTO_STEP_EN, AUTO_PERIOD=8, no button -> disp_index advances every 9 cycles (8 SHOW + 1 LOAD). A button press coinciding with auto-advance -> single increment.
